// File: rtl/game_pkg.sv
// Shared constants, state encoding and helpers for the game pixel generator.
package game_pkg;

    localparam int unsigned H_ACTIVE_DEF = 640;
    localparam int unsigned V_ACTIVE_DEF = 480;
    localparam int unsigned POS_W        = 11;
    localparam int unsigned MAX_OBS      = 8;
    localparam int unsigned RGB_W        = 12;
    localparam int unsigned SCORE_W      = 16;

    // Colour bit order is {B,G,R}
    localparam logic [RGB_W-1:0] RED   = 12'h00F;
    localparam logic [RGB_W-1:0] GREEN = 12'h0F0;
    localparam logic [RGB_W-1:0] WHITE = 12'hFFF;
    localparam logic [RGB_W-1:0] BLACK = 12'h000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        OVER = 2'd2
    } game_state_e;

    // Number of obstacles wrapping on a single frame tick
    function automatic logic [3:0] count_ones(input logic [MAX_OBS-1:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < int'(MAX_OBS); i++) begin
            n = n + 4'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/game_pixel_gen_if.sv
// Pixel-side bus between the VGA sync/controls and the game pixel generator.
interface game_pixel_gen_if;
    import game_pkg::*;

    logic                 video_on;
    logic [9:0]           x;
    logic [9:0]           y;
    logic                 btn_up;
    logic                 btn_down;
    logic                 start;
    logic [RGB_W-1:0]     rgb;
    logic                 game_over;
    logic [SCORE_W-1:0]   score;

    modport master (
        output video_on, x, y, btn_up, btn_down, start,
        input  rgb, game_over, score
    );

    modport slave (
        input  video_on, x, y, btn_up, btn_down, start,
        output rgb, game_over, score
    );

endinterface

// File: rtl/frame_tick_gen.sv
// Single-clk pulse on the first clk that sees the pixel counter at (0, V_ACTIVE).
module frame_tick_gen
    import game_pkg::*;
#(
    parameter int unsigned V_ACTIVE = V_ACTIVE_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] x,
    input  logic [9:0] y,
    output logic       frame_tick
);

    logic at_tick;
    logic at_tick_q;

    assign at_tick    = (x == 10'd0) && (y == 10'(V_ACTIVE));
    assign frame_tick = at_tick && !at_tick_q;

    // Edge detect so a slow pixel clock still yields one pulse per frame
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            at_tick_q <= 1'b0;
        end else begin
            at_tick_q <= at_tick;
        end
    end

endmodule

// File: rtl/game_pixel_gen.sv
// Game state (player box, scrolling obstacles, collision, score) and registered RGB.
module game_pixel_gen
    import game_pkg::*;
#(
    parameter int unsigned N_OBS      = 4,
    parameter int unsigned H_ACTIVE   = H_ACTIVE_DEF,
    parameter int unsigned V_ACTIVE   = V_ACTIVE_DEF,
    parameter int unsigned BOX_X      = 40,
    parameter int unsigned BOX_Y0     = 200,
    parameter int unsigned BOX_W      = 51,
    parameter int unsigned BOX_H      = 50,
    parameter int unsigned OBS_W      = 145,
    parameter int unsigned OBS_H      = 30,
    parameter int unsigned OBS_Y_BASE = 60,
    parameter int unsigned OBS_Y_STEP = 100,
    parameter int unsigned OBS_X_STEP = 120,
    parameter int unsigned OBS_SPEED  = 2,
    parameter int unsigned BOX_SPEED  = 3
) (
    input  logic             clk,
    input  logic             reset,
    game_pixel_gen_if.slave  bus
);

    localparam int unsigned PW = POS_W;

    localparam logic [PW-1:0] BOX_L      = PW'(BOX_X);
    localparam logic [PW-1:0] BOX_R      = PW'(BOX_X + BOX_W);
    localparam logic [PW-1:0] BOX_H_L    = PW'(BOX_H);
    localparam logic [PW-1:0] BOX_Y_INIT = PW'(BOX_Y0);
    localparam logic [PW-1:0] BOX_Y_MAX  = PW'(V_ACTIVE - BOX_H);
    localparam logic [PW-1:0] BOX_DN_LIM = PW'(V_ACTIVE - BOX_H - BOX_SPEED);
    localparam logic [PW-1:0] BOX_SPD    = PW'(BOX_SPEED);
    localparam logic [PW-1:0] OBS_SPD    = PW'(OBS_SPEED);
    localparam logic [PW-1:0] OBS_W_L    = PW'(OBS_W);
    localparam logic [PW-1:0] OBS_X_LOAD = PW'(H_ACTIVE - OBS_W);

    game_state_e        state;
    logic               hit;
    logic               frame_tick;
    logic [PW-1:0]      box_y;
    logic [PW-1:0]      box_next;
    logic [PW-1:0]      px;
    logic [PW-1:0]      py;
    logic [PW-1:0]      obs_xs [N_OBS];
    logic [N_OBS-1:0]   obs_on;
    logic [N_OBS-1:0]   wrap;
    logic               box_on;
    logic               advance;
    logic               restore;
    logic [SCORE_W:0]   score_sum;
    logic [SCORE_W-1:0] score;
    logic               game_over;
    logic [RGB_W-1:0]   rgb;

    frame_tick_gen #(
        .V_ACTIVE (V_ACTIVE)
    ) u_frame_tick (
        .clk        (clk),
        .reset      (reset),
        .x          (bus.x),
        .y          (bus.y),
        .frame_tick (frame_tick)
    );

    assign px      = PW'(bus.x);
    assign py      = PW'(bus.y);
    assign advance = (state == PLAY) && frame_tick && !hit;
    assign restore = (state == IDLE) || ((state == OVER) && bus.start);
    assign box_on  = (px >= BOX_L) && (px < BOX_R) &&
                     (py >= box_y) && (py < box_y + BOX_H_L);

    // Obstacles: per-index position register, scroll left and wrap
    for (genvar gi = 0; gi < int'(N_OBS); gi++) begin : g_obs
        localparam logic [PW-1:0] X_INIT = PW'(H_ACTIVE - OBS_W - gi * OBS_X_STEP);
        localparam logic [PW-1:0] Y_TOP  = PW'(OBS_Y_BASE + gi * OBS_Y_STEP);
        localparam logic [PW-1:0] Y_BOT  = PW'(OBS_Y_BASE + gi * OBS_Y_STEP + OBS_H);

        logic [PW-1:0] pos_x;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                pos_x <= X_INIT;
            end else if (restore) begin
                pos_x <= X_INIT;
            end else if (advance) begin
                pos_x <= wrap[gi] ? OBS_X_LOAD : pos_x - OBS_SPD;
            end
        end

        assign wrap[gi]   = pos_x < OBS_SPD;
        assign obs_on[gi] = (px >= pos_x) && (px < pos_x + OBS_W_L) &&
                            (py >= Y_TOP) && (py < Y_BOT);
        assign obs_xs[gi] = pos_x;
    end

    // Button-driven player movement with clamping at both screen edges
    always_comb begin
        box_next = box_y;
        if (bus.btn_up && !bus.btn_down) begin
            box_next = (box_y < BOX_SPD) ? '0 : box_y - BOX_SPD;
        end else if (bus.btn_down && !bus.btn_up) begin
            box_next = (box_y > BOX_DN_LIM) ? BOX_Y_MAX : box_y + BOX_SPD;
        end
    end

    assign score_sum = (SCORE_W+1)'(score) + (SCORE_W+1)'(count_ones(MAX_OBS'(wrap)));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            hit       <= 1'b0;
            box_y     <= BOX_Y_INIT;
            score     <= '0;
            game_over <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    hit       <= 1'b0;
                    box_y     <= BOX_Y_INIT;
                    score     <= '0;
                    game_over <= 1'b0;
                    if (bus.start) begin
                        state <= PLAY;
                    end
                end
                PLAY: begin
                    if (frame_tick && hit) begin
                        state     <= OVER;
                        hit       <= 1'b0;
                        game_over <= 1'b1;
                    end else begin
                        if (frame_tick) begin
                            box_y <= box_next;
                            score <= score_sum[SCORE_W] ? {SCORE_W{1'b1}}
                                                        : score_sum[SCORE_W-1:0];
                        end
                        if (bus.video_on && box_on && (|obs_on)) begin
                            hit <= 1'b1;
                        end
                    end
                end
                OVER: begin
                    if (bus.start) begin
                        state     <= IDLE;
                        box_y     <= BOX_Y_INIT;
                        score     <= '0;
                        game_over <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    hit       <= 1'b0;
                    game_over <= 1'b0;
                end
            endcase
        end
    end

    // Pixel colour with box over obstacles over background
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rgb <= BLACK;
        end else if (!bus.video_on) begin
            rgb <= BLACK;
        end else if (box_on) begin
            rgb <= (state == OVER) ? WHITE : GREEN;
        end else if (|obs_on) begin
            rgb <= RED;
        end else begin
            rgb <= BLACK;
        end
    end

    assign bus.rgb       = rgb;
    assign bus.score     = score;
    assign bus.game_over = game_over;

endmodule

// File: tb/tb_game_pixel_gen.sv
// Directed self-checking bench for game_pixel_gen.
module tb_game_pixel_gen;
    import game_pkg::*;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    game_pixel_gen_if bus ();
    game_pixel_gen_if bus2 ();

    game_pixel_gen dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Every obstacle wraps on every tick here, giving eight score increments per frame
    game_pixel_gen #(
        .N_OBS      (8),
        .OBS_X_STEP (10),
        .OBS_SPEED  (600)
    ) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic pix(input int px, input int py, output logic [11:0] c);
        @(negedge clk);
        bus.x = 10'(px);
        bus.y = 10'(py);
        bus.video_on = 1'b1;
        @(posedge clk);
        #1;
        c = bus.rgb;
        bus.video_on = 1'b0;
        bus.x = 10'd1;
        bus.y = 10'd0;
    endtask

    task automatic frames(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.x = 10'd0;
            bus.y = 10'd480;
            @(negedge clk);
            bus.x = 10'd1;
            bus.y = 10'd0;
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        logic [11:0] c;
        int tx [9] = '{40, 0, 90, 91, 40, 495, 494, 639, 639};
        int ty [9] = '{200, 0, 249, 200, 250, 60, 60, 89, 90};
        logic [11:0] te [9] = '{GREEN, BLACK, GREEN, BLACK, BLACK, RED, BLACK, RED, BLACK};
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        // Render the box and enter PLAY, then reset mid-frame
        @(negedge clk);
        bus.x = 10'd40; bus.y = 10'd200; bus.video_on = 1'b1; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        #2 reset = 1'b1;
        #1;
        n_tests++;
        if (bus.rgb !== BLACK) begin
            n_fail++; $display("FAIL reset_rgb: got %h expected %h", bus.rgb, BLACK);
        end
        n_tests++;
        if (bus.score !== 16'd0) begin
            n_fail++; $display("FAIL reset_score: got %h expected 0", bus.score);
        end
        n_tests++;
        if (bus.game_over !== 1'b0) begin
            n_fail++; $display("FAIL reset_game_over: got %b expected 0", bus.game_over);
        end
        n_tests++;
        if (dut.state !== IDLE) begin
            n_fail++; $display("FAIL reset_state: got %0d expected %0d", dut.state, IDLE);
        end
        @(negedge clk);
        bus.video_on = 1'b0; bus.x = 10'd1; bus.y = 10'd0;
        reset = 1'b0;
        for (int i = 0; i < 9; i++) begin
            pix(tx[i], ty[i], c);
            n_tests++;
            if (c !== te[i]) begin
                n_fail++;
                $display("FAIL idle_pixel(%0d,%0d): got %h expected %h", tx[i], ty[i], c, te[i]);
            end
        end
    endtask

    task automatic test_scroll();
        logic [11:0] c;
        int ex [4] = '{475, 355, 235, 115};
        pulse_start();
        frames(10);
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (dut.obs_xs[i] !== 11'(ex[i])) begin
                n_fail++; $display("FAIL scroll_x%0d: got %0d expected %0d", i, dut.obs_xs[i], ex[i]);
            end
        end
        n_tests++;
        if (dut.box_y !== 11'd200) begin
            n_fail++; $display("FAIL scroll_box_y: got %0d expected 200", dut.box_y);
        end
        pix(475, 60, c);
        n_tests++;
        if (c !== RED) begin
            n_fail++; $display("FAIL scroll_edge_in: got %h expected %h", c, RED);
        end
        pix(474, 60, c);
        n_tests++;
        if (c !== BLACK) begin
            n_fail++; $display("FAIL scroll_edge_out: got %h expected %h", c, BLACK);
        end
    endtask

    task automatic test_start_in_play();
        pulse_start();
        n_tests++;
        if (dut.state !== PLAY || dut.obs_xs[0] !== 11'd475) begin
            n_fail++; $display("FAIL start_in_play: state %0d x0 %0d expected %0d 475", dut.state, dut.obs_xs[0], PLAY);
        end
    endtask

    task automatic test_box_move();
        // Frames 11..90: up clamps at 0; x3 wraps on frame 68
        bus.btn_up = 1'b1;
        frames(80);
        bus.btn_up = 1'b0;
        n_tests++;
        if (dut.box_y !== 11'd0) begin
            n_fail++; $display("FAIL up_clamp: got %0d expected 0", dut.box_y);
        end
        n_tests++;
        if (bus.score !== 16'd1) begin
            n_fail++; $display("FAIL score_after_90: got %0d expected 1", bus.score);
        end
        // Frames 91..240: down clamps at 430
        bus.btn_down = 1'b1;
        frames(150);
        n_tests++;
        if (dut.box_y !== 11'd430) begin
            n_fail++; $display("FAIL down_clamp: got %0d expected 430", dut.box_y);
        end
        // Frames 241..245: both buttons, no movement
        bus.btn_up = 1'b1;
        frames(5);
        bus.btn_up = 1'b0;
        bus.btn_down = 1'b0;
        n_tests++;
        if (dut.box_y !== 11'd430) begin
            n_fail++; $display("FAIL both_buttons: got %0d expected 430", dut.box_y);
        end
    endtask

    task automatic test_wrap();
        frames(2);
        n_tests++;
        if (dut.obs_xs[0] !== 11'd1 || bus.score !== 16'd3) begin
            n_fail++; $display("FAIL pre_wrap: x0 %0d score %0d expected 1 3", dut.obs_xs[0], bus.score);
        end
        frames(1);
        n_tests++;
        if (dut.obs_xs[0] !== 11'd495) begin
            n_fail++; $display("FAIL wrap_x0: got %0d expected 495", dut.obs_xs[0]);
        end
        n_tests++;
        if (bus.score !== 16'd4) begin
            n_fail++; $display("FAIL wrap_score: got %0d expected 4", bus.score);
        end
    endtask

    task automatic test_collision();
        logic [11:0] c;
        // Frames 249..338 move box to 160, frames 339..400 let obstacle 1 reach x=71
        bus.btn_up = 1'b1;
        frames(90);
        bus.btn_up = 1'b0;
        frames(62);
        n_tests++;
        if (dut.box_y !== 11'd160 || dut.obs_xs[1] !== 11'd71 || bus.score !== 16'd6) begin
            n_fail++; $display("FAIL pre_hit: box %0d x1 %0d score %0d expected 160 71 6", dut.box_y, dut.obs_xs[1], bus.score);
        end
        pix(80, 170, c);
        n_tests++;
        if (c !== GREEN) begin
            n_fail++; $display("FAIL overlap_pixel: got %h expected %h", c, GREEN);
        end
        n_tests++;
        if (dut.hit !== 1'b1 || bus.game_over !== 1'b0) begin
            n_fail++; $display("FAIL hit_set: hit %b game_over %b expected 1 0", dut.hit, bus.game_over);
        end
        @(negedge clk);
        bus.x = 10'd0; bus.y = 10'd480;
        @(posedge clk);
        #1;
        n_tests++;
        if (bus.game_over !== 1'b1) begin
            n_fail++; $display("FAIL game_over_rise: got %b expected 1", bus.game_over);
        end
        @(negedge clk);
        bus.x = 10'd1; bus.y = 10'd0;
        n_tests++;
        if (dut.hit !== 1'b0 || dut.box_y !== 11'd160 || dut.obs_xs[0] !== 11'd191 || bus.score !== 16'd6) begin
            n_fail++; $display("FAIL hit_tick_frozen: hit %b box %0d x0 %0d score %0d expected 0 160 191 6", dut.hit, dut.box_y, dut.obs_xs[0], bus.score);
        end
        pix(80, 170, c);
        n_tests++;
        if (c !== WHITE) begin
            n_fail++; $display("FAIL over_box_colour: got %h expected %h", c, WHITE);
        end
        bus.btn_down = 1'b1;
        frames(3);
        bus.btn_down = 1'b0;
        n_tests++;
        if (dut.box_y !== 11'd160 || dut.obs_xs[1] !== 11'd71 || bus.score !== 16'd6 || bus.game_over !== 1'b1) begin
            n_fail++; $display("FAIL over_frozen: box %0d x1 %0d score %0d go %b expected 160 71 6 1", dut.box_y, dut.obs_xs[1], bus.score, bus.game_over);
        end
    endtask

    task automatic test_restart();
        logic [11:0] c;
        int ex [4] = '{495, 375, 255, 135};
        pulse_start();
        n_tests++;
        if (dut.state !== IDLE || bus.game_over !== 1'b0 || bus.score !== 16'd0 || dut.box_y !== 11'd200) begin
            n_fail++; $display("FAIL restart: state %0d go %b score %0d box %0d expected 0 0 0 200", dut.state, bus.game_over, bus.score, dut.box_y);
        end
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (dut.obs_xs[i] !== 11'(ex[i])) begin
                n_fail++; $display("FAIL restart_x%0d: got %0d expected %0d", i, dut.obs_xs[i], ex[i]);
            end
        end
        pix(40, 200, c);
        n_tests++;
        if (c !== GREEN) begin
            n_fail++; $display("FAIL restart_pixel: got %h expected %h", c, GREEN);
        end
    endtask

    task automatic test_start_with_tick();
        @(negedge clk);
        bus.start = 1'b1; bus.x = 10'd0; bus.y = 10'd480;
        @(posedge clk);
        #1;
        n_tests++;
        if (dut.state !== PLAY || dut.obs_xs[0] !== 11'd495) begin
            n_fail++; $display("FAIL start_tick: state %0d x0 %0d expected %0d 495", dut.state, dut.obs_xs[0], PLAY);
        end
        @(negedge clk);
        bus.start = 1'b0; bus.x = 10'd1; bus.y = 10'd0;
        frames(1);
        n_tests++;
        if (dut.obs_xs[0] !== 11'd493) begin
            n_fail++; $display("FAIL first_move: got %0d expected 493", dut.obs_xs[0]);
        end
    endtask

    task automatic test_saturate();
        @(negedge clk);
        bus2.start = 1'b1;
        @(negedge clk);
        bus2.start = 1'b0;
        for (int f = 1; f <= 8193; f++) begin
            @(negedge clk);
            bus2.x = 10'd0; bus2.y = 10'd480;
            @(negedge clk);
            bus2.x = 10'd1; bus2.y = 10'd0;
            if (f == 1) begin
                n_tests++;
                if (bus2.score !== 16'd8) begin
                    n_fail++; $display("FAIL multi_wrap: got %0d expected 8", bus2.score);
                end
            end else if (f == 8191) begin
                n_tests++;
                if (bus2.score !== 16'hFFF8) begin
                    n_fail++; $display("FAIL near_sat: got %h expected fff8", bus2.score);
                end
            end else if (f >= 8192) begin
                n_tests++;
                if (bus2.score !== 16'hFFFF) begin
                    n_fail++; $display("FAIL saturate_%0d: got %h expected ffff", f, bus2.score);
                end
            end
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b1;
        bus.video_on = 1'b0;  bus.x = 10'd1;  bus.y = 10'd0;
        bus.btn_up = 1'b0;    bus.btn_down = 1'b0;  bus.start = 1'b0;
        bus2.video_on = 1'b0; bus2.x = 10'd1; bus2.y = 10'd0;
        bus2.btn_up = 1'b0;   bus2.btn_down = 1'b0; bus2.start = 1'b0;
        test_reset();
        test_scroll();
        test_start_in_play();
        test_box_move();
        test_wrap();
        test_collision();
        test_restart();
        test_start_with_tick();
        test_saturate();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
